// File: rtl/cms_trace_filter.sv
// cms_trace_filter
//
// Front stage of the continuous monitoring system. Watches the CPU retirement trace and
// forwards only instructions that carry control-flow information (control-flow
// instructions, their targets, sync points and optional periodic resync points) as
// {instr, pc} packets over a single-entry valid/ready register. Packets that arrive while
// the register is full and not being drained are dropped and flagged by a sticky overflow.
//
// Optional feature macro: CMS_TRACE_RESYNC_EN
//   defined   -> resync counter forces a packet after RESYNC_TIMER_RESET_VALUE consecutive
//                suppressed instructions
//   undefined -> no counter; only CF, target and sync rules forward instructions
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   filtering enable; trace inputs ignored while low
//   in_valid   in   one retired instruction this cycle
//   in_pc      in   PC of the retired instruction
//   in_instr   in   instruction word (compressed forms in [15:0])
//   out_valid  out  packet register holds a packet
//   out_ready  in   downstream accepts the packet this cycle
//   out_pkt    out  {instr, pc}
//   overflow   out  sticky: a packet was dropped since reset

module cms_trace_filter #(
   parameter int unsigned XLEN                     = 64,
   parameter int unsigned INSTR_WIDTH              = 32,
   parameter int unsigned PKT_WIDTH                = INSTR_WIDTH + XLEN,
   parameter int unsigned RESYNC_TIMER_WIDTH       = 8,
   parameter int unsigned RESYNC_TIMER_RESET_VALUE = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PKT_WIDTH-1:0]   out_pkt,
   output logic                   overflow
);

   // Reload value must fit in the counter.
   if (RESYNC_TIMER_RESET_VALUE >= (64'd1 << RESYNC_TIMER_WIDTH)) begin : g_bad_resync_cfg
      $error("RESYNC_TIMER_RESET_VALUE does not fit in RESYNC_TIMER_WIDTH bits");
   end

   logic                 sync_pending_q, sync_pending_d;
   logic                 target_pending_q, target_pending_d;
   logic                 out_valid_q, out_valid_d;
   logic [PKT_WIDTH-1:0] out_pkt_q, out_pkt_d;
   logic                 overflow_q, overflow_d;
   logic                 is_cf;
   logic                 resync_hit;
   logic                 fire;

`ifdef CMS_TRACE_RESYNC_EN
   localparam logic [RESYNC_TIMER_WIDTH-1:0] CntReload =
      RESYNC_TIMER_WIDTH'(RESYNC_TIMER_RESET_VALUE);

   logic [RESYNC_TIMER_WIDTH-1:0] cnt_q, cnt_d;

   assign resync_hit = (cnt_q == '0);

   // The counter only decrements on a suppressed instruction, and a zero count always
   // forwards, so it can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = CntReload;
      end else if (in_valid) begin
         cnt_d = fire ? CntReload : (cnt_q - RESYNC_TIMER_WIDTH'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= CntReload;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign resync_hit = 1'b0;
`endif

   // Control-flow decode for uncompressed and compressed encodings.
   always_comb begin
      is_cf = 1'b0;
      unique case (in_instr[1:0])
         2'b11: begin
            is_cf = (in_instr[6:0] == 7'b1100011) ||
                    (in_instr[6:0] == 7'b1101111) ||
                    (in_instr[6:0] == 7'b1100111);
         end
         2'b01: begin
            is_cf = (in_instr[15:14] == 2'b11) || (in_instr[15:13] == 3'b101);
         end
         2'b10: begin
            // c.jr / c.jalr; rs1 = 0 is reserved / c.ebreak, rs2 != 0 is c.mv / c.add.
            is_cf = (in_instr[15:13] == 3'b100) && (in_instr[6:2] == 5'd0) &&
                    (in_instr[11:7] != 5'd0);
         end
         default: is_cf = 1'b0;
      endcase
   end

   assign fire = en && in_valid && (is_cf || target_pending_q || sync_pending_q || resync_hit);

   always_comb begin
      sync_pending_d   = sync_pending_q;
      target_pending_d = target_pending_q;
      out_valid_d      = out_valid_q;
      out_pkt_d        = out_pkt_q;
      overflow_d       = overflow_q;

      // Holding sync set for the whole disabled period makes the first instruction after
      // any 0->1 edge of en a sync point without needing an edge detector.
      if (!en) begin
         sync_pending_d   = 1'b1;
         target_pending_d = 1'b0;
      end else if (fire) begin
         sync_pending_d   = 1'b0;
         target_pending_d = is_cf;
      end

      // Filter state above advances even when the packet itself is dropped.
      if (fire) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_pkt_d   = {in_instr, in_pc};
         end else begin
            overflow_d  = 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_pending_q   <= 1'b1;
         target_pending_q <= 1'b0;
         out_valid_q      <= 1'b0;
         out_pkt_q        <= '0;
         overflow_q       <= 1'b0;
      end else begin
         sync_pending_q   <= sync_pending_d;
         target_pending_q <= target_pending_d;
         out_valid_q      <= out_valid_d;
         out_pkt_q        <= out_pkt_d;
         overflow_q       <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pkt   = out_pkt_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_cms_trace_filter.sv
module tb_cms_trace_filter;

   localparam int unsigned R = 10;
`ifdef CMS_TRACE_RESYNC_EN
   localparam bit ResyncEn = 1'b1;
`else
   localparam bit ResyncEn = 1'b0;
`endif

   localparam logic [31:0] Addi = 32'h0000_0013;
   localparam logic [31:0] Beq  = 32'h0000_0463;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        in_valid;
   logic [63:0] in_pc;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [95:0] out_pkt;
   logic        overflow;

   int checks;
   int errors;

   // Reference model state (spec-level view)
   bit          m_valid;
   logic [95:0] m_pkt;
   bit          m_ovf;
   bit          m_sync;
   bit          m_tgt;
   int          m_run;      // consecutive suppressed instructions since last forward
   bit          m_prev_en;

   cms_trace_filter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pkt   (out_pkt),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit ref_is_cf(input logic [31:0] w);
      if (w[1:0] == 2'b11) return (w[6:0] == 7'h63) || (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
      if (w[1:0] == 2'b01) return (w[15:14] == 2'b11) || (w[15:13] == 3'b101);
      if (w[1:0] == 2'b10) return (w[15:13] == 3'b100) && (w[6:2] == 5'd0) && (w[11:7] != 5'd0);
      return 1'b0;
   endfunction

   // Drive one cycle, advance the model at the edge, return 1 time unit after the edge.
   task automatic step(input bit r, input bit e, input bit v, input logic [63:0] pc,
                       input logic [31:0] ins, input bit rdy);
      bit fwd;
      bit cf;
      rst_n = r; en = e; in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy;
      @(posedge clk);
      if (!r) begin
         m_valid = 0; m_pkt = '0; m_ovf = 0; m_sync = 1; m_tgt = 0; m_run = 0;
         m_prev_en = 0;
      end else begin
         fwd = 0;
         if (!e) begin
            m_tgt = 0;
            m_run = 0;
         end else begin
            if (!m_prev_en) m_sync = 1;
            if (v) begin
               cf  = ref_is_cf(ins);
               fwd = cf || m_tgt || m_sync || (ResyncEn && m_run == R);
               if (fwd) begin
                  m_sync = 0; m_tgt = cf; m_run = 0;
               end else begin
                  m_run++;
               end
            end
         end
         if (fwd) begin
            if (!m_valid || rdy) begin
               m_valid = 1; m_pkt = {ins, pc};
            end else begin
               m_ovf = 1;
            end
         end else if (rdy) begin
            m_valid = 0;
         end
         m_prev_en = e;
      end
      #1;
   endtask

   task automatic test_reset();
      step(0, 1, 1, 64'h10, Beq, 1);
      step(0, 1, 1, 64'h14, Beq, 0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_pkt !== 96'd0) begin
         errors++; $display("FAIL reset_pkt: got %h expected 0", out_pkt);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
      end
   endtask

   task automatic test_sync_stream();
      logic [63:0] pc;
      bit exp_v;
      step(0, 1, 0, 64'h0, 32'h0, 1);
      for (int i = 0; i < 15; i++) begin
         pc = 64'h1000 + 64'(4 * i);
         step(1, 1, 1, pc, Addi, 1);
         exp_v = (i == 0) || (ResyncEn && i == 11);
         checks++;
         if (out_valid !== exp_v) begin
            errors++; $display("FAIL sync_stream_valid[%0d]: got %b expected %b", i, out_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (out_pkt !== {Addi, pc}) begin
               errors++; $display("FAIL sync_stream_pkt[%0d]: got %h expected %h", i, out_pkt, {Addi, pc});
            end
         end
      end
   endtask

   task automatic test_cf_target();
      logic [63:0] pcs [3] = '{64'h2000, 64'h2008, 64'h200C};
      logic [31:0] ins [3] = '{Beq, Addi, Addi};
      bit          ev  [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, pcs[i], ins[i], 1);
         checks++;
         if (out_valid !== ev[i]) begin
            errors++; $display("FAIL cf_target_valid[%0d]: got %b expected %b", i, out_valid, ev[i]);
         end
         if (ev[i]) begin
            checks++;
            if (out_pkt !== {ins[i], pcs[i]}) begin
               errors++; $display("FAIL cf_target_pkt[%0d]: got %h expected %h", i, out_pkt, {ins[i], pcs[i]});
            end
         end
      end
   endtask

   task automatic test_compressed();
      logic [31:0] ins [6] = '{32'h8082, Addi, 32'hA001, Addi, 32'h8002, 32'h4501};
      bit          ev  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [63:0] pc;
      for (int i = 0; i < 6; i++) begin
         pc = 64'h3000 + 64'(4 * i);
         step(1, 1, 1, pc, ins[i], 1);
         checks++;
         if (out_valid !== ev[i]) begin
            errors++; $display("FAIL compressed_valid[%0d]: got %b expected %b", i, out_valid, ev[i]);
         end
         if (ev[i]) begin
            checks++;
            if (out_pkt !== {ins[i], pc}) begin
               errors++; $display("FAIL compressed_pkt[%0d]: got %h expected %h", i, out_pkt, {ins[i], pc});
            end
         end
      end
   endtask

   task automatic test_overflow();
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_initial: got %b expected 0", overflow);
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, 64'h4000 + 64'(4 * i), Beq, 0);
         checks++;
         if (out_valid !== 1'b1 || out_pkt !== {Beq, 64'h4000}) begin
            errors++;
            $display("FAIL ovf_hold[%0d]: got v=%b pkt=%h expected v=1 pkt=%h",
                     i, out_valid, out_pkt, {Beq, 64'h4000});
         end
         checks++;
         if (overflow !== (i > 0)) begin
            errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, overflow, (i > 0));
         end
      end
      step(1, 1, 0, 64'h0, 32'h0, 1);
      checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain: got v=%b ovf=%b expected v=0 ovf=1", out_valid, overflow);
      end
      // Last dropped beq still left its target pending.
      step(1, 1, 1, 64'h400C, Addi, 1);
      checks++;
      if (out_valid !== 1'b1 || out_pkt !== {Addi, 64'h400C}) begin
         errors++;
         $display("FAIL ovf_target_after_drop: got v=%b pkt=%h expected v=1 pkt=%h",
                  out_valid, out_pkt, {Addi, 64'h400C});
      end
   endtask

   task automatic test_en_toggle();
      step(1, 1, 1, 64'h5000, Beq, 1);
      step(1, 0, 1, 64'h5004, Beq, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL en_off_ignored0: got %b expected 0", out_valid);
      end
      step(1, 0, 1, 64'h5008, Addi, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL en_off_ignored1: got %b expected 0", out_valid);
      end
      step(1, 1, 1, 64'h500C, Addi, 1);
      checks++;
      if (out_valid !== 1'b1 || out_pkt !== {Addi, 64'h500C}) begin
         errors++;
         $display("FAIL en_resync: got v=%b pkt=%h expected v=1 pkt=%h",
                  out_valid, out_pkt, {Addi, 64'h500C});
      end
      step(1, 1, 1, 64'h5010, Addi, 1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL en_after_sync: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] pc;
      step(1, 1, 1, 64'h6000, Beq, 0);
      step(1, 1, 1, 64'h6004, Beq, 0);
      checks++;
      if (out_valid !== 1'b1 || overflow !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre: got v=%b ovf=%b expected v=1 ovf=1", out_valid, overflow);
      end
      step(0, 1, 1, 64'h6008, Addi, 1);
      checks++;
      if (out_valid !== 1'b0 || out_pkt !== 96'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got v=%b pkt=%h ovf=%b expected v=0 pkt=0 ovf=0",
                  out_valid, out_pkt, overflow);
      end
      for (int i = 0; i < 13; i++) begin
         pc = 64'h7000 + 64'(4 * i);
         step(1, 1, 1, pc, Addi, 1);
         checks++;
         if (out_valid !== m_valid || out_pkt !== m_pkt) begin
            errors++;
            $display("FAIL rst_mid_stream[%0d]: got v=%b pkt=%h expected v=%b pkt=%h",
                     i, out_valid, out_pkt, m_valid, m_pkt);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] pool [10] = '{Addi, Beq, 32'h0000_006F, 32'h0000_00E7, 32'h8082,
                                 32'hA001, 32'hC001, 32'h8002, 32'h4501, 32'h9082};
      logic [31:0] ins;
      bit r, e, v, rdy;
      int k;
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 199) != 0);
         e   = ($urandom_range(0, 19) != 0);
         v   = ($urandom_range(0, 9) < 7);
         rdy = ($urandom_range(0, 9) < 6);
         k   = $urandom_range(0, 19);
         if (k < 10)      ins = Addi;
         else if (k < 19) ins = pool[k - 9];
         else             ins = $urandom;
         step(r, e, v, {$urandom, $urandom}, ins, rdy);
         checks++;
         if (out_valid !== m_valid || out_pkt !== m_pkt || overflow !== m_ovf) begin
            errors++;
            $display("FAIL random[%0d]: got v=%b pkt=%h ovf=%b expected v=%b pkt=%h ovf=%b",
                     n, out_valid, out_pkt, overflow, m_valid, m_pkt, m_ovf);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      m_valid = 0; m_pkt = '0; m_ovf = 0; m_sync = 1; m_tgt = 0; m_run = 0; m_prev_en = 0;
      test_reset();
      test_sync_stream();
      test_cf_target();
      test_compressed();
      test_overflow();
      test_en_toggle();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cms_trace_filter.md
# cms_trace_filter

- Front stage of the continuous monitoring system: sits between the CPU retirement trace port and the packet FIFO that feeds the monitoring logic.
- Passes through only retired instructions that carry control-flow information: control-flow instructions, their targets, a sync point, and periodic resync points.
- Emits each as a `{instr, pc}` data packet over a valid/ready interface.
- Sticky overflow flag marks packets dropped under downstream backpressure.

## Interface
- `XLEN`, 64, program counter width
- `INSTR_WIDTH`, 32, instruction width
- `PKT_WIDTH`, `INSTR_WIDTH + XLEN` (96), packet width
- `RESYNC_TIMER_WIDTH`, 8, resync counter width
- `RESYNC_TIMER_RESET_VALUE`, 10, resync counter reload value

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `en`  in  1  filtering enabled; inputs ignored while low
- `in_valid`  in  1  one retired instruction this cycle; no backpressure
- `in_pc`  in  XLEN  PC of the retired instruction
- `in_instr`  in  INSTR_WIDTH  instruction word; compressed instructions in `[15:0]`
- `out_valid`  out  1  packet register holds a packet
- `out_ready`  in  1  downstream accepts the packet this cycle
- `out_pkt`  out  PKT_WIDTH  `{instr[95:64], pc[63:0]}`
- `overflow`  out  1  sticky; at least one packet dropped since reset

## Operation
- Decode applies to valid instructions with `en`=1.
- Uncompressed instructions (`instr[1:0]`=11) are control flow (CF) when `instr[6:0]` equals one of:
  - 1100011 (branch)
  - 1101111 (jal)
  - 1100111 (jalr)
- Compressed instructions are CF when any of these holds:
  - `[1:0]`=01 and `[15:14]`=11 (c.beqz/c.bnez)
  - `[1:0]`=01 and `[15:13]`=101 (c.j)
  - `[1:0]`=10, `[15:13]`=100, `[6:2]`=0 and `[11:7]`≠0 (c.jr/c.jalr)
- A valid instruction is forwarded if any of these holds:
  - it is CF
  - `target_pending`=1 (it is the target of the previous CF)
  - `sync_pending`=1
  - the resync counter is 0 (only with `CMS_TRACE_RESYNC_EN`)
- Forwarding any instruction:
  - clears `sync_pending`
  - sets `target_pending` to that instruction's CF status, so consecutive CF instructions are all forwarded
  - reloads the counter
- A suppressed valid instruction decrements the counter.
- `sync_pending` is set by reset and on every 0→1 transition of `en`.
- While `en`=0:
  - `target_pending` is cleared
  - the counter holds its reload value
  - the packet register still drains normally
- Packet register, for each forwarded instruction:
  - if `out_valid`=0 or `out_ready`=1, load the packet and set `out_valid`=1
  - otherwise drop it, set `overflow`=1, and leave the register unchanged
  - a dropped packet still updates all state (pending flags, counter) exactly as if it had been forwarded
- `out_valid` clears on a cycle with `out_ready`=1 and no new packet.
- `overflow` clears only on reset.

## Timing
- Latency: instruction at cycle N appears on `out_pkt` with `out_valid`=1 at cycle N+1.
- Throughput: one packet per cycle when `out_ready` stays 1.
- Simultaneous handshake and new packet: the register is replaced in the same edge and `out_valid` stays 1.
- Reset values:
  - `out_valid`=0
  - `out_pkt`=0
  - `overflow`=0
  - `sync_pending`=1
  - `target_pending`=0
  - counter=`RESYNC_TIMER_RESET_VALUE`
- Reset mid-operation discards any held packet; no handshake completes on a reset cycle.
- Counter never wraps: at 0, the next valid instruction is forwarded and the counter reloads.
- With reload value R, at most R consecutive instructions are suppressed; the (R+1)th is forwarded.
- Cycles with `in_valid`=0 change no filter state.

## Configuration
- Macro: `CMS_TRACE_RESYNC_EN`.
- Defined: the resync counter is present and forces a packet after `RESYNC_TIMER_RESET_VALUE` consecutive suppressed instructions.
- Undefined: no counter logic. Only CF, target and sync rules forward instructions; any number of non-CF instructions may be suppressed.

## Test plan
- Reset, `en`=1, `out_ready`=1, stream of addi (0x00000013) at pc 0x1000, 0x1004, ... → first packet `{0x00000013, 0x1000}` at cycle+1 (sync).
  - With macro: 11th addi after it (pc 0x102C) forwarded.
  - Without macro: no further packets.
- Sync'd stream: beq (0x00000463) at pc 0x2000, then addi at 0x2008 → both forwarded back-to-back; the following addi is suppressed.
- Compressed: 0x8082 (c.jr ra) and 0xA001 (c.j) forwarded. 0x8002 (rs1=0) and 0x4501 (c.li) suppressed.
- `out_ready`=0 with three forwarded instructions in consecutive cycles → first held in `out_pkt`, others dropped, `overflow`=1. `out_ready`=1 → `out_valid` drops next cycle, `overflow` stays 1.
- Toggle `en` 1→0→1 mid-stream with `target_pending` set → target flag cleared, first valid instruction after re-enable forwarded as sync.
- Assert `rst_n`=0 while `out_valid`=1 → next cycle `out_valid`=0, `out_pkt`=0, `overflow`=0, counter=10.
